// File: rtl/cnn_acc_pkg.sv
// Shared constants and FSM state type for the CNN accelerator weight path.
package cnn_acc_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 72;
  localparam int unsigned ROM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } wf_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// First-word-fall-through skid FIFO; the head entry and the non-empty flag are
// flops, so dout/empty are driven directly from registers.
module weight_skid_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 73
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             not_empty;
  logic [AW-1:0]    wr_idx;
  logic [CW-1:0]    count_nxt;

  // Shift-down storage: a pop moves every entry one slot toward the head,
  // so a simultaneous push lands one slot lower than it otherwise would.
  always_comb begin
    wr_idx    = AW'(count - CW'(pop));
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= din;
      count     <= count_nxt;
      not_empty <= (count_nxt != '0);
    end
  end

  assign dout  = mem[0];
  assign empty = ~not_empty;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams cfg_len consecutive weight-ROM words from cfg_base to one PE, using
// credit-limited issue and a skid FIFO to absorb ROM latency under backpressure.
module weight_fetch_ctrl #(
  parameter int unsigned ADDR_W     = cnn_acc_pkg::ADDR_W,
  parameter int unsigned DATA_W     = cnn_acc_pkg::DATA_W,
  parameter int unsigned ROM_LAT    = cnn_acc_pkg::ROM_LAT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready
);

  import cnn_acc_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  if (FIFO_DEPTH < ROM_LAT + 2) begin : g_depth_chk
    $error("weight_fetch_ctrl: FIFO_DEPTH must be >= ROM_LAT+2");
  end

  wf_state_t         state;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] recv_cnt;
  logic [ROM_LAT-1:0] inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occ;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_dout;
  logic              pop;
  logic              push;
  logic              push_last;
  logic              issue;

  // occ counts every word issued but not yet popped (current rom_en, pipe,
  // FIFO); a pop this cycle frees a credit in time for the next issue.
  always_comb begin
    pop       = w_valid & w_ready;
    push      = inflight[ROM_LAT-1];
    push_last = (recv_cnt == len_r - ADDR_W'(1));
    occ       = fifo_count + CW'($countones(inflight)) + CW'(rom_en);
    issue     = 1'b0;
    case (state)
      IDLE:    issue = start && (cfg_len != '0);
      FETCH:   issue = (issue_cnt < len_r) && ((occ - CW'(pop)) < CW'(FIFO_DEPTH));
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_r     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      done     <= 1'b0;
      rom_en   <= issue;
      inflight <= (inflight << 1) | ROM_LAT'(rom_en);
      if (push) recv_cnt <= recv_cnt + ADDR_W'(1);
      if (issue) begin
        rom_addr  <= (state == IDLE) ? cfg_base : rom_addr + ADDR_W'(1);
        issue_cnt <= (state == IDLE) ? ADDR_W'(1) : issue_cnt + ADDR_W'(1);
      end
      case (state)
        IDLE: if (start) begin
          len_r    <= cfg_len;
          recv_cnt <= '0;
          if (cfg_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= (cfg_len == ADDR_W'(1)) ? DRAIN : FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: if (issue && (issue_cnt + ADDR_W'(1) == len_r)) state <= DRAIN;
        DRAIN: if (pop && w_last) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The last-word flag travels with its data so w_last stays aligned under stalls.
  weight_skid_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .din   ({push_last, rom_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign w_valid = ~fifo_empty;
  assign w_last  = fifo_dout[DATA_W];
  assign w_data  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a latency-2 ROM model and a
// scoreboard of expected addresses and words.
module tb_weight_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] cfg_base;
  logic [13:0] cfg_len;
  logic        busy, done, rom_en;
  logic [13:0] rom_addr;
  logic [71:0] rom_dout, rom_r1;
  logic        w_valid, w_last, w_ready;
  logic [71:0] w_data;

  int total = 0;
  int bad   = 0;
  int cyc_no, n_en, n_done, first_valid, first_en, last_en, done_at, last_at;

  logic [13:0] addr_q [$];
  logic [71:0] exp_q  [$];
  logic        last_q [$];

  weight_fetch_ctrl #(
    .ADDR_W(14), .DATA_W(72), .ROM_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .w_valid(w_valid), .w_data(w_data), .w_last(w_last),
    .w_ready(w_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] rom_word(input logic [13:0] a);
    return {a, ~a, a ^ 14'h2A5A, a + 14'd7, 2'b10, a};
  endfunction

  // ROM with address register and output register: two-cycle read latency.
  always @(posedge clk) begin
    if (rom_en) rom_r1 <= rom_word(rom_addr);
    rom_dout <= rom_r1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    total++;
    assert (cond) else begin
      bad++;
      $error("FAIL %s: observed 0 expected 1", tag);
    end
  endtask

  // Evaluate the current cycle (inputs already driven), then advance.
  task automatic cyc();
    if (rom_en) begin
      if (first_en < 0) first_en = cyc_no;
      last_en = cyc_no;
      n_en++;
      chk_true("rom_en_expected", addr_q.size() != 0);
      if (addr_q.size() != 0) chk("rom_addr", 128'(rom_addr), 128'(addr_q.pop_front()));
    end
    if (done) begin
      n_done++;
      done_at = cyc_no;
      chk("busy_at_done", 128'(busy), 128'(0));
    end
    if (w_valid && first_valid < 0) first_valid = cyc_no;
    if (w_valid && w_ready) begin
      chk_true("word_expected", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("w_data", 128'(w_data), 128'(exp_q.pop_front()));
        chk("w_last", 128'(w_last), 128'(last_q.pop_front()));
      end
      if (w_last) last_at = cyc_no;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic launch(input logic [13:0] base, input logic [13:0] len);
    logic [13:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 14'(i);
      addr_q.push_back(a);
      exp_q.push_back(rom_word(a));
      last_q.push_back(i == int'(len) - 1);
    end
    n_en = 0; n_done = 0; first_valid = -1; first_en = -1; last_en = -1;
    done_at = -1; last_at = -1;
    start = 1'b1; cfg_base = base; cfg_len = len;
    cyc_no = 0;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd_ready);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rnd_ready) w_ready = 1'($urandom_range(0, 1));
      seen = done;
      cyc();
    end
    chk_true("done_within_budget", seen);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    128'(busy),     128'(0));
    chk({tag, "_done"},    128'(done),     128'(0));
    chk({tag, "_rom_en"},  128'(rom_en),   128'(0));
    chk({tag, "_rom_addr"},128'(rom_addr), 128'(0));
    chk({tag, "_w_valid"}, 128'(w_valid),  128'(0));
    chk({tag, "_w_data"},  128'(w_data),   128'(0));
    chk({tag, "_w_last"},  128'(w_last),   128'(0));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0; w_ready = 1'b0;
    cyc_no = 0; n_en = 0; n_done = 0; first_valid = -1; first_en = -1;
    last_en = -1; done_at = -1; last_at = -1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    cyc(); cyc();

    // Basic stream
    w_ready = 1'b1;
    launch(14'h0010, 14'd4);
    chk("basic_busy_c1", 128'(busy), 128'(1));
    run_until_done(30, 1'b0);
    chk("basic_first_en", 128'(first_en), 128'(1));
    chk("basic_last_en", 128'(last_en), 128'(4));
    chk("basic_n_en", 128'(n_en), 128'(4));
    chk("basic_first_valid", 128'(first_valid), 128'(4));
    chk("basic_last_at", 128'(last_at), 128'(7));
    chk("basic_done_at", 128'(done_at), 128'(8));
    chk("basic_q_empty", 128'(exp_q.size()), 128'(0));
    cyc();

    // Backpressure: stall the PE, expect four issues and a full FIFO
    w_ready = 1'b0;
    launch(14'h0200, 14'd16);
    repeat (11) cyc();
    chk("bp_n_en_stall", 128'(n_en), 128'(4));
    chk("bp_valid_stall", 128'(w_valid), 128'(1));
    chk("bp_head_data", 128'(w_data), 128'(exp_q[0]));
    chk("bp_head_last", 128'(w_last), 128'(0));
    w_ready = 1'b1;
    run_until_done(80, 1'b0);
    chk("bp_n_en", 128'(n_en), 128'(16));
    chk("bp_n_done", 128'(n_done), 128'(1));
    chk("bp_q_empty", 128'(exp_q.size()), 128'(0));
    cyc();

    // Zero length
    launch(14'h0055, 14'd0);
    chk("zero_done_c1", 128'(done), 128'(1));
    chk("zero_busy_c1", 128'(busy), 128'(0));
    chk("zero_rom_en_c1", 128'(rom_en), 128'(0));
    repeat (5) cyc();
    chk("zero_n_en", 128'(n_en), 128'(0));
    chk("zero_no_valid", 128'(first_valid), 128'(-1));
    chk("zero_n_done", 128'(n_done), 128'(1));

    // Address wrap
    w_ready = 1'b1;
    launch(14'h3FFE, 14'd4);
    run_until_done(30, 1'b0);
    chk("wrap_n_en", 128'(n_en), 128'(4));
    chk("wrap_q_empty", 128'(exp_q.size()), 128'(0));
    cyc();

    // Random backpressure
    launch(14'h1234, 14'd9);
    run_until_done(200, 1'b1);
    chk("rnd_q_empty", 128'(exp_q.size()), 128'(0));
    chk("rnd_n_done", 128'(n_done), 128'(1));
    w_ready = 1'b1;
    cyc();

    // Reset mid-command: DRAIN with two words buffered
    w_ready = 1'b0;
    launch(14'h0300, 14'd4);
    repeat (4) cyc();
    chk("mid_valid_before_rst", 128'(w_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    addr_q.delete(); exp_q.delete(); last_q.delete();
    repeat (4) cyc();
    chk("midrst_no_done", 128'(n_done), 128'(0));
    rst = 1'b1;
    cyc();
    w_ready = 1'b1;
    launch(14'h0100, 14'd2);
    run_until_done(30, 1'b0);
    chk("post_rst_q_empty", 128'(exp_q.size()), 128'(0));
    chk("post_rst_n_en", 128'(n_en), 128'(2));
    cyc();

    // Start while busy is ignored
    launch(14'h0040, 14'd6);
    cyc();
    start = 1'b1; cfg_base = 14'h0700; cfg_len = 14'd3;
    cyc();
    start = 1'b0;
    run_until_done(40, 1'b0);
    chk("busy_start_n_en", 128'(n_en), 128'(6));
    chk("busy_start_q_empty", 128'(exp_q.size()), 128'(0));

    // Start in the cycle right after done
    launch(14'h0020, 14'd3);
    chk("after_done_rom_en", 128'(rom_en), 128'(1));
    chk("after_done_busy", 128'(busy), 128'(1));
    run_until_done(30, 1'b0);
    repeat (4) cyc();
    chk("after_done_n_done", 128'(n_done), 128'(1));
    chk("after_done_q_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
